// File: rtl/pcie_wr_arb_pkg.sv
// Shared DMA definitions: arbiter FSM states, error counter width, round-robin pick helper.
// rr_pick searches from ptr+1 with wrap-around over the lowest n bits of eligible (n <= 8).
package pcie_dma_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_CPL  = 2'd2
    } arb_state_e;

    // Walk the search order backwards so the last hit is the first eligible index after ptr.
    function automatic int rr_pick(input logic [7:0] eligible, input int ptr, input int n);
        int pick;
        int idx;
        pick = ptr;
        for (int k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = (ptr + k) % n;
                if (eligible[idx[2:0]]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pcie_wr_arb_if.sv
// Requester-side and write-controller-side signals of the write arbiter.
// master = arbiter view; slave = requesters plus write request controller.
interface pcie_wr_arb_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_en;
    logic [N_REQ-1:0]        req_done;
    logic [N_REQ-1:0]        req_err;

    logic                    RqValid;
    logic [ADDR_W-1:0]       RqAddr;
    logic [DATA_W-1:0]       RqData;
    logic                    RqReady;
    logic                    RqErr;

    modport master (
        input  req_valid, req_addr, req_data, req_en, RqReady, RqErr,
        output req_done, req_err, RqValid, RqAddr, RqData
    );

    modport slave (
        output req_valid, req_addr, req_data, req_en, RqReady, RqErr,
        input  req_done, req_err, RqValid, RqAddr, RqData
    );
endinterface

// File: rtl/pcie_wr_arb_rr.sv
// Combinational round-robin pick: first eligible index after ptr, wrapping; any_valid = |eligible.
// Zero latency, no state; shared with the read-side arbiter.
module rr_arb_core
    import pcie_dma_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_valid
);

    always_comb begin
        idx       = IDX_W'(rr_pick(8'(eligible), int'(ptr), N_REQ));
        any_valid = |eligible;
    end

endmodule

// File: rtl/pcie_wr_arb.sv
// Round-robin sharer of the single-beat write request controller among N_REQ requesters.
// Grant 1 cycle after req_valid; request held until RqReady, done/err pulse the cycle after.
module pcie_wr_arb
    import pcie_dma_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 128,
    parameter int TO_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pcie_wr_arb_if.master            bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic [ERR_CNT_W-1:0]     err_cnt,
    output logic                     timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TO_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TO_CYC - 1);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("pcie_wr_arb: N_REQ must be in 2..8");
    end
    if (TO_CYC < 2) begin : g_bad_to_cyc
        $error("pcie_wr_arb: TO_CYC must be at least 2");
    end

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    gnt_q;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_vld;
    logic                grant;
    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    done_vec;
    logic                rq_valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WD_W-1:0]     wd_cnt_q;
    logic                timeout_q;

    // req_en only matters here, so masking it mid-transaction never aborts the grant in flight.
    assign eligible = bus.req_valid & bus.req_en;

    rr_arb_core #(.N_REQ(N_REQ)) u_rr (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .idx       (pick_idx),
        .any_valid (pick_vld)
    );

    assign grant = (state_q == ARB_IDLE) && pick_vld;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (pick_vld)    state_d = ARB_BUSY;
            ARB_BUSY: if (bus.RqReady) state_d = ARB_CPL;
            ARB_CPL:                   state_d = ARB_IDLE;
            default:                   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            gnt_q      <= '0;
            rq_valid_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_q      <= pick_idx;
                ptr_q      <= pick_idx;
                addr_q     <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
                data_q     <= bus.req_data[pick_idx*DATA_W +: DATA_W];
                rq_valid_q <= 1'b1;
            end else if (state_q == ARB_BUSY && bus.RqReady) begin
                rq_valid_q <= 1'b0;
            end
        end
    end

    // Watchdog only flags; the transaction keeps waiting for RqReady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (grant) begin
            wd_cnt_q <= '0;
        end else if (state_q == ARB_BUSY) begin
            if (wd_cnt_q != WD_MAX) wd_cnt_q <= wd_cnt_q + 1'b1;
            if (wd_cnt_q == WD_MAX) timeout_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (state_q == ARB_CPL && bus.RqErr && err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    always_comb begin
        done_vec = '0;
        if (state_q == ARB_CPL) done_vec[gnt_q] = 1'b1;
    end

    assign bus.req_done = done_vec;
    assign bus.req_err  = done_vec & {N_REQ{bus.RqErr}};
    assign bus.RqValid  = rq_valid_q;
    assign bus.RqAddr   = addr_q;
    assign bus.RqData   = data_q;

    assign busy    = (state_q != ARB_IDLE);
    assign gnt_idx = gnt_q;
    assign err_cnt = err_cnt_q;
    assign timeout = timeout_q;

endmodule
